fetch_fifo: RTL and testbench

- Sits directly upstream of the ID stage, between the instruction-fetch frontend and the decode stage.
- Accepts 32-bit word-aligned fetch responses and realigns them into individual 16-bit (compressed) or 32-bit instructions, including 32-bit instructions that straddle a word boundary.
- Buffers the instructions as ariane_pkg::fetch_entry_t entries and presents them to ID using a valid/ack handshake.

---
 rtl/fetch_fifo.sv | 203 ++++++++++++++++++++
 tb/tb_fetch_fifo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_fifo.sv
// Instruction realignment FIFO between the fetch frontend and ID: splits 32-bit
// fetch words into compressed/full instructions and queues them as fetch entries.

package riscv;
  localparam logic [63:0] INSTR_PAGE_FAULT = 64'd12;
endpackage

package ariane_pkg;
  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0] predict_address;
    logic        predict_taken;
    logic        valid;
  } branchpredict_sbe_t;

  typedef struct packed {
    logic [63:0]        address;
    logic [31:0]        instruction;
    branchpredict_sbe_t branch_predict;
    exception_t         ex;
  } fetch_entry_t;
endpackage

// Simulation-only occupancy guard; synthesis ignores the assertion.
module fetch_fifo_chk #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input logic             clk_i,
  input logic             rst_ni,
  input logic [CNT_W-1:0] count_d
);
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_d <= CNT_W'(DEPTH));
endmodule

module fetch_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [63:0]              in_addr_i,
  input  logic [31:0]              in_rdata_i,
  input  logic                     in_ex_i,
  output ariane_pkg::fetch_entry_t fetch_entry_o,
  output logic                     fetch_entry_valid_o,
  input  logic                     fetch_ack_i
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  ariane_pkg::fetch_entry_t mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pending_q;
  logic [15:0]      pend_instr_q;
  logic [63:0]      pend_addr_q;

  logic                     accept_s;
  logic                     pop_s;
  logic [63:0]              upper_addr_s;
  logic                     upper_straddle_s;
  logic                     lo_valid_s;
  ariane_pkg::fetch_entry_t lo_entry_s;
  logic                     do_upper_s;
  logic                     up_valid_s;
  logic                     up_pend_s;
  ariane_pkg::fetch_entry_t up_entry_s;
  ariane_pkg::fetch_entry_t entry0_s;
  ariane_pkg::fetch_entry_t entry1_s;
  logic [1:0]               n_push_s;
  logic [1:0]               n_eff_s;
  logic [CNT_W-1:0]         count_d_s;
  logic [PTR_W-1:0]         wr_ptr_nx_s;

  function automatic ariane_pkg::fetch_entry_t make_entry(input logic [63:0] addr,
                                                          input logic [31:0] instr);
    ariane_pkg::fetch_entry_t e;
    e             = '0;
    e.address     = addr;
    e.instruction = instr;
    return e;
  endfunction

  function automatic ariane_pkg::fetch_entry_t make_fault(input logic [63:0] addr);
    ariane_pkg::fetch_entry_t e;
    e          = '0;
    e.address  = addr;
    e.ex.valid = 1'b1;
    e.ex.cause = riscv::INSTR_PAGE_FAULT;
    e.ex.tval  = addr;
    return e;
  endfunction

  assign in_ready_o          = (CNT_W'(DEPTH) - count_q) >= CNT_W'(2);
  assign fetch_entry_valid_o = (count_q != CNT_W'(0));
  assign fetch_entry_o       = fetch_entry_valid_o ? mem_q[rd_ptr_q] : '0;

  assign accept_s         = in_valid_i && in_ready_o && !flush_i;
  assign pop_s            = fetch_ack_i && fetch_entry_valid_o && !flush_i;
  assign upper_addr_s     = {in_addr_i[63:2], 2'b10};
  assign upper_straddle_s = (in_rdata_i[17:16] == 2'b11);
  assign up_entry_s       = make_entry(upper_addr_s, {16'h0000, in_rdata_i[31:16]});
  assign up_valid_s       = do_upper_s && !upper_straddle_s;
  assign up_pend_s        = do_upper_s && upper_straddle_s;
  assign wr_ptr_nx_s      = wr_ptr_q + PTR_W'(1);

  // Lower-halfword decode: completes a pending straddler or emits the low instruction.
  always_comb begin
    lo_valid_s = 1'b0;
    lo_entry_s = '0;
    do_upper_s = 1'b0;
    if (in_ex_i) begin
      lo_valid_s = 1'b1;
      lo_entry_s = make_fault(pending_q ? pend_addr_q : in_addr_i);
    end else if (pending_q) begin
      lo_valid_s = 1'b1;
      lo_entry_s = make_entry(pend_addr_q, {in_rdata_i[15:0], pend_instr_q});
      do_upper_s = 1'b1;
    end else if (!in_addr_i[1] && (in_rdata_i[1:0] == 2'b11)) begin
      lo_valid_s = 1'b1;
      lo_entry_s = make_entry(in_addr_i, in_rdata_i);
    end else if (!in_addr_i[1]) begin
      lo_valid_s = 1'b1;
      lo_entry_s = make_entry(in_addr_i, {16'h0000, in_rdata_i[15:0]});
      do_upper_s = 1'b1;
    end else begin
      do_upper_s = 1'b1;
    end
  end

  // Pack emitted entries in program order and derive the next occupancy.
  always_comb begin
    entry0_s = '0;
    entry1_s = '0;
    if (lo_valid_s) begin
      entry0_s = lo_entry_s;
      entry1_s = up_entry_s;
    end else begin
      entry0_s = up_entry_s;
      entry1_s = '0;
    end
    n_push_s  = {1'b0, lo_valid_s} + {1'b0, up_valid_s};
    n_eff_s   = accept_s ? n_push_s : 2'd0;
    count_d_s = count_q + CNT_W'(n_eff_s) - CNT_W'(pop_s);
  end

  // Storage, pointers, occupancy and straddle state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      pending_q    <= 1'b0;
      pend_instr_q <= 16'h0000;
      pend_addr_q  <= 64'h0;
    end else if (flush_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      if (n_eff_s != 2'd0) begin
        mem_q[wr_ptr_q] <= entry0_s;
      end
      if (n_eff_s == 2'd2) begin
        mem_q[wr_ptr_nx_s] <= entry1_s;
      end
      wr_ptr_q <= wr_ptr_q + PTR_W'(n_eff_s);
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d_s;
      if (accept_s) begin
        pending_q <= up_pend_s;
        if (up_pend_s) begin
          pend_instr_q <= in_rdata_i[31:16];
          pend_addr_q  <= upper_addr_s;
        end
      end
    end
  end

  fetch_fifo_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .count_d (count_d_s)
  );

endmodule

// File: tb/tb_fetch_fifo.sv
// Bench for fetch_fifo: directed vector table, then random traffic checked
// against a halfword-stream reference model.
module tb_fetch_fifo;

  logic                     clk;
  logic                     rst_ni;
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [63:0]              in_addr;
  logic [31:0]              in_rdata;
  logic                     in_ex;
  ariane_pkg::fetch_entry_t fetch_entry;
  logic                     fe_valid;
  logic                     ack;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_fifo #(.DEPTH(4)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .flush_i             (flush),
    .in_valid_i          (in_valid),
    .in_ready_o          (in_ready),
    .in_addr_i           (in_addr),
    .in_rdata_i          (in_rdata),
    .in_ex_i             (in_ex),
    .fetch_entry_o       (fetch_entry),
    .fetch_entry_valid_o (fe_valid),
    .fetch_ack_i         (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl, v, ex, ack;
    logic [63:0] addr;
    logic [31:0] data;
    logic        e_valid, e_ready, e_exv;
    logic [63:0] e_addr;
    logic [31:0] e_instr;
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] instr;
    logic        exv;
  } mentry_t;

  typedef struct {
    logic [63:0] addr;
    logic [15:0] hw;
  } half_t;

  vec_t    vq[$];
  mentry_t mq[$];
  half_t   hq[$];

  function automatic vec_t mk(logic fl, logic v, logic [63:0] addr, logic [31:0] data,
                              logic ex, logic a, logic ev, logic er,
                              logic [63:0] ea, logic [31:0] ei, logic exv);
    vec_t t;
    t.fl = fl; t.v = v; t.addr = addr; t.data = data; t.ex = ex; t.ack = a;
    t.e_valid = ev; t.e_ready = er; t.e_addr = ea; t.e_instr = ei; t.e_exv = exv;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; in_addr = 64'h0; in_rdata = 32'h0;
    in_ex = 1'b0; ack = 1'b0;
  endtask

  // Reference: accepted words become a halfword stream that is parsed into instructions.
  task automatic model_push_word(input logic [63:0] addr, input logic [31:0] data, input logic ex);
    mentry_t e;
    half_t   h;
    if (ex) begin
      e.addr  = (hq.size() != 0) ? hq[0].addr : addr;
      e.instr = 32'h0;
      e.exv   = 1'b1;
      mq.push_back(e);
      hq.delete();
    end else begin
      if (addr[1] == 1'b0) begin
        h.addr = {addr[63:2], 2'b00}; h.hw = data[15:0];
        hq.push_back(h);
      end
      h.addr = {addr[63:2], 2'b10}; h.hw = data[31:16];
      hq.push_back(h);
      while (hq.size() != 0) begin
        if (hq[0].hw[1:0] != 2'b11) begin
          e.addr = hq[0].addr; e.instr = {16'h0, hq[0].hw}; e.exv = 1'b0;
          mq.push_back(e);
          void'(hq.pop_front());
        end else if (hq.size() >= 2) begin
          e.addr = hq[0].addr; e.instr = {hq[1].hw, hq[0].hw}; e.exv = 1'b0;
          mq.push_back(e);
          void'(hq.pop_front());
          void'(hq.pop_front());
        end else begin
          break;
        end
      end
    end
  endtask

  logic [63:0] word_addr;
  logic [15:0] hw_lo, hw_hi;
  logic        r_fl, r_v, r_ack, r_ex, r_acc, r_pop;
  logic [63:0] r_addr;
  logic [31:0] r_data;

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", fe_valid, 1'b0);
    check("reset_ready", in_ready, 1'b1);
    check("reset_entry_nonzero", 64'(fetch_entry != '0), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    //              fl    v     addr          data          ex    ack   ev    er    e_addr        e_instr       exv
    vq.push_back(mk(1'b0, 1'b1, 64'h80000000, 32'h00000013, 1'b0, 1'b0, 1'b1, 1'b1, 64'h80000000, 32'h00000013, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 64'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 64'h0,        32'h0,        1'b0));
    vq.push_back(mk(1'b0, 1'b1, 64'h1000,     32'h00010001, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1000,     32'h00000001, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 64'h0,        32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 64'h1002,     32'h00000001, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 64'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 64'h0,        32'h0,        1'b0));
    vq.push_back(mk(1'b0, 1'b1, 64'h2000,     32'h00130001, 1'b0, 1'b0, 1'b1, 1'b1, 64'h2000,     32'h00000001, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 64'h2004,     32'h00010000, 1'b0, 1'b1, 1'b1, 1'b1, 64'h2002,     32'h00000013, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 64'h0,        32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 64'h2006,     32'h00000001, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 64'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 64'h0,        32'h0,        1'b0));
    // backpressure: fill to 4, drain while a blocked word waits
    vq.push_back(mk(1'b0, 1'b1, 64'h1000,     32'h00010001, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1000,     32'h00000001, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 64'h1004,     32'h00050005, 1'b0, 1'b0, 1'b1, 1'b0, 64'h1000,     32'h00000001, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 64'h1008,     32'h00090009, 1'b0, 1'b1, 1'b1, 1'b0, 64'h1002,     32'h00000001, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 64'h1008,     32'h00090009, 1'b0, 1'b1, 1'b1, 1'b1, 64'h1004,     32'h00000005, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 64'h1008,     32'h00090009, 1'b0, 1'b1, 1'b1, 1'b0, 64'h1006,     32'h00000005, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 64'h0,        32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 64'h1008,     32'h00000009, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 64'h0,        32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 64'h100A,     32'h00000009, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 64'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 64'h0,        32'h0,        1'b0));
    // flush with three entries queued and a straddler pending
    vq.push_back(mk(1'b0, 1'b1, 64'h1000,     32'h00010001, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1000,     32'h00000001, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 64'h2000,     32'h00130001, 1'b0, 1'b0, 1'b1, 1'b0, 64'h1000,     32'h00000001, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 64'h5000,     32'h00010001, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0,        32'h0,        1'b0));
    vq.push_back(mk(1'b0, 1'b1, 64'h3002,     32'h00000013, 1'b0, 1'b0, 1'b1, 1'b1, 64'h3002,     32'h00000000, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 64'h3004,     32'h00010001, 1'b0, 1'b1, 1'b1, 1'b1, 64'h3004,     32'h00000001, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 64'h0,        32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 64'h3006,     32'h00000001, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 64'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 64'h0,        32'h0,        1'b0));
    // page fault while a straddler is pending
    vq.push_back(mk(1'b0, 1'b1, 64'h3FFC,     32'h00130001, 1'b0, 1'b0, 1'b1, 1'b1, 64'h3FFC,     32'h00000001, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 64'h4000,     32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 64'h3FFE,     32'h00000000, 1'b1));
    vq.push_back(mk(1'b0, 1'b1, 64'h4004,     32'h00010001, 1'b0, 1'b1, 1'b1, 1'b1, 64'h4004,     32'h00000001, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 64'h0,        32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 64'h4006,     32'h00000001, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 64'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 64'h0,        32'h0,        1'b0));
    vq.push_back(mk(1'b0, 1'b0, 64'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 64'h0,        32'h0,        1'b0));
    vq.push_back(mk(1'b0, 1'b1, 64'h5000,     32'h12345677, 1'b1, 1'b0, 1'b1, 1'b1, 64'h5000,     32'h00000000, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 64'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 64'h0,        32'h0,        1'b0));

    for (int i = 0; i < vq.size(); i++) begin
      flush = vq[i].fl; in_valid = vq[i].v; in_addr = vq[i].addr;
      in_rdata = vq[i].data; in_ex = vq[i].ex; ack = vq[i].ack;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), fe_valid, vq[i].e_valid);
      check($sformatf("vec%0d_ready", i), in_ready, vq[i].e_ready);
      if (vq[i].e_valid) begin
        check($sformatf("vec%0d_addr", i), fetch_entry.address, vq[i].e_addr);
        check($sformatf("vec%0d_instr", i), fetch_entry.instruction, vq[i].e_instr);
        check($sformatf("vec%0d_exv", i), fetch_entry.ex.valid, vq[i].e_exv);
        check($sformatf("vec%0d_bp", i), 64'(fetch_entry.branch_predict != '0), 64'd0);
        if (vq[i].e_exv) begin
          check($sformatf("vec%0d_tval", i), fetch_entry.ex.tval, vq[i].e_addr);
          check($sformatf("vec%0d_cause", i), fetch_entry.ex.cause, 64'd12);
        end
      end
    end
    idle_inputs();
    @(posedge clk);
    #1;

    // Random traffic against the reference model (FIFO is empty, nothing pending).
    word_addr = 64'h8000_0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd_valid", fe_valid, 1'(mq.size() != 0));
      check("rnd_ready", in_ready, 1'((4 - mq.size()) >= 2));
      if (mq.size() != 0) begin
        check("rnd_addr", fetch_entry.address, mq[0].addr);
        check("rnd_instr", fetch_entry.instruction, mq[0].instr);
        check("rnd_exv", fetch_entry.ex.valid, mq[0].exv);
        if (mq[0].exv) check("rnd_tval", fetch_entry.ex.tval, mq[0].addr);
      end
      r_fl  = ($urandom_range(0, 59) == 0);
      r_v   = ($urandom_range(0, 3) != 0);
      r_ack = ($urandom_range(0, 2) != 0);
      r_ex  = ($urandom_range(0, 24) == 0);
      hw_lo = 16'($urandom);
      hw_hi = 16'($urandom);
      if ($urandom_range(0, 1) == 1) hw_lo[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) hw_hi[1:0] = 2'b11;
      r_data = {hw_hi, hw_lo};
      r_addr = word_addr;
      if (hq.size() == 0 && $urandom_range(0, 3) == 0) r_addr[1] = 1'b1;
      flush = r_fl; in_valid = r_v; in_addr = r_addr; in_rdata = r_data;
      in_ex = r_ex; ack = r_ack;
      r_acc = r_v && ((4 - mq.size()) >= 2) && !r_fl;
      r_pop = r_ack && (mq.size() != 0) && !r_fl;
      @(posedge clk);
      #1;
      if (r_fl) begin
        mq.delete();
        hq.delete();
      end else begin
        if (r_pop) void'(mq.pop_front());
        if (r_acc) begin
          model_push_word(r_addr, r_data, r_ex);
          word_addr = word_addr + 64'd4;
        end
      end
    end

    // Asynchronous reset in the middle of traffic.
    flush = 1'b0; in_valid = 1'b1; in_addr = 64'h6000; in_rdata = 32'h00010001;
    in_ex = 1'b0; ack = 1'b0;
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    check("midrst_valid", fe_valid, 1'b0);
    check("midrst_ready", in_ready, 1'b1);
    check("midrst_entry_nonzero", 64'(fetch_entry != '0), 64'd0);
    idle_inputs();
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", fe_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
